// File: rtl/ps2_morse_encoder.sv
// PS/2 keyboard to Morse transmitter: receives set-2 scan codes, buffers A-Z/0-9/space,
// and on Enter plays the buffer as timed dit/dah elements.
module ps2_morse_encoder #(
  parameter int UNIT_CYCLES    = 5000,
  parameter int BUF_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic dit_out,
  output logic dah_out,
  output logic morse_out,
  output logic busy
);

  localparam int AW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNTW = $clog2(BUF_DEPTH + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int UW   = $clog2(4 * UNIT_CYCLES + 1);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(BUF_DEPTH);
  localparam logic [UW-1:0] DOT_END   = UW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] DAH_END   = UW'(3 * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] CGS_LAST  = UW'(2 * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] CGS_PRE   = UW'(2 * UNIT_CYCLES - 2);
  localparam logic [UW-1:0] CGL_LAST  = UW'(4 * UNIT_CYCLES - 1);
  localparam logic [UW-1:0] CGL_PRE   = UW'(4 * UNIT_CYCLES - 2);

  typedef enum logic [2:0] {P_IDLE, P_FETCH, P_ELEM_ON, P_ELEM_GAP, P_CHAR_GAP} play_state_t;

  // {length[2:0], pattern[4:0]}; first element in pattern[4], 1 = dash. Zero = not a letter/digit.
  function automatic logic [7:0] morse_rom(input logic [7:0] code);
    case (code)
      8'h1C: morse_rom = {3'd2, 5'b01000};  8'h32: morse_rom = {3'd4, 5'b10000};
      8'h21: morse_rom = {3'd4, 5'b10100};  8'h23: morse_rom = {3'd3, 5'b10000};
      8'h24: morse_rom = {3'd1, 5'b00000};  8'h2B: morse_rom = {3'd4, 5'b00100};
      8'h34: morse_rom = {3'd3, 5'b11000};  8'h33: morse_rom = {3'd4, 5'b00000};
      8'h43: morse_rom = {3'd2, 5'b00000};  8'h3B: morse_rom = {3'd4, 5'b01110};
      8'h42: morse_rom = {3'd3, 5'b10100};  8'h4B: morse_rom = {3'd4, 5'b01000};
      8'h3A: morse_rom = {3'd2, 5'b11000};  8'h31: morse_rom = {3'd2, 5'b10000};
      8'h44: morse_rom = {3'd3, 5'b11100};  8'h4D: morse_rom = {3'd4, 5'b01100};
      8'h15: morse_rom = {3'd4, 5'b11010};  8'h2D: morse_rom = {3'd3, 5'b01000};
      8'h1B: morse_rom = {3'd3, 5'b00000};  8'h2C: morse_rom = {3'd1, 5'b10000};
      8'h3C: morse_rom = {3'd3, 5'b00100};  8'h2A: morse_rom = {3'd4, 5'b00010};
      8'h1D: morse_rom = {3'd3, 5'b01100};  8'h22: morse_rom = {3'd4, 5'b10010};
      8'h35: morse_rom = {3'd4, 5'b10110};  8'h1A: morse_rom = {3'd4, 5'b11000};
      8'h45: morse_rom = {3'd5, 5'b11111};  8'h16: morse_rom = {3'd5, 5'b01111};
      8'h1E: morse_rom = {3'd5, 5'b00111};  8'h26: morse_rom = {3'd5, 5'b00011};
      8'h25: morse_rom = {3'd5, 5'b00001};  8'h2E: morse_rom = {3'd5, 5'b00000};
      8'h36: morse_rom = {3'd5, 5'b10000};  8'h3D: morse_rom = {3'd5, 5'b11000};
      8'h3E: morse_rom = {3'd5, 5'b11100};  8'h46: morse_rom = {3'd5, 5'b11110};
      default: morse_rom = 8'h00;
    endcase
  endfunction

  function automatic logic is_char(input logic [7:0] code);
    return (code == 8'h29) || (morse_rom(code) != 8'h00);
  endfunction

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [1:0] clk_sync, data_sync;
  logic       clk_prev, sample, sdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sample = clk_prev & ~clk_sync[1];
  assign sdata  = data_sync[1];

  // Receiver: byte_valid is a one-cycle strobe qualifying rx_byte; the decoder consumes it
  // in that cycle unconditionally (no backpressure, so there is no ready).
  logic          rx_active, byte_valid;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [7:0]    rx_byte;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_active  <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      to_cnt     <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (sample) begin
        to_cnt <= '0;
        if (!rx_active) begin
          if (!sdata) begin
            rx_active <= 1'b1;
            bit_cnt   <= 4'd1;
          end
        end else if (bit_cnt == 4'd10) begin
          rx_active <= 1'b0;
          bit_cnt   <= '0;
          if (sdata && ^shreg) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg[7:0];
          end
        end else begin
          shreg   <= {sdata, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (rx_active) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_active <= 1'b0;
          bit_cnt   <= '0;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  logic [7:0]      mem [BUF_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            skip_next, push, pop, clear, start, fifo_empty;

  assign fifo_empty = (count == '0);

  // Prefix handling runs even during playback; everything else waits for idle.
  always_comb begin
    push  = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    if (byte_valid && !busy && !skip_next && rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
      if (rx_byte == 8'h5A)      start = !fifo_empty;
      else if (rx_byte == 8'h0C) clear = 1'b1;
      else if (is_char(rx_byte)) push  = (count != FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_next <= 1'b0;
    end else if (byte_valid && rx_byte != 8'hE0) begin
      if (skip_next)              skip_next <= 1'b0;
      else if (rx_byte == 8'hF0)  skip_next <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= next_ptr(wr_ptr);
      count  <= count + CNTW'(1);
    end else if (pop) begin
      rd_ptr <= next_ptr(rd_ptr);
      count  <= count - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  play_state_t   state, next_state;
  logic [UW-1:0] ucnt;
  logic [4:0]    pat;
  logic [2:0]    elems;
  logic          gap_long;
  logic [7:0]    head_rom;

  assign head_rom = morse_rom(mem[rd_ptr]);
  assign pop      = (state == P_FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= P_IDLE;
      ucnt  <= '0;
    end else begin
      state <= next_state;
      ucnt  <= (next_state != state) ? '0 : ucnt + UW'(1);
    end
  end

  // The FETCH cycle is borrowed from the preceding letter gap, so gaps between
  // characters stay exact multiples of the unit; the final gap runs its full length.
  always_comb begin
    next_state = state;
    case (state)
      P_IDLE:     if (start) next_state = P_FETCH;
      P_FETCH:    next_state = (head_rom[7:5] == 3'd0) ? P_CHAR_GAP : P_ELEM_ON;
      P_ELEM_ON:  if (ucnt == (pat[4] ? DAH_END : DOT_END)) next_state = P_ELEM_GAP;
      P_ELEM_GAP: if (ucnt == DOT_END) next_state = (elems == 3'd1) ? P_CHAR_GAP : P_ELEM_ON;
      P_CHAR_GAP: begin
        if (fifo_empty) begin
          if (ucnt == (gap_long ? CGL_LAST : CGS_LAST)) next_state = P_IDLE;
        end else if (ucnt == (gap_long ? CGL_PRE : CGS_PRE)) begin
          next_state = P_FETCH;
        end
      end
      default:    next_state = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat      <= '0;
      elems    <= '0;
      gap_long <= 1'b0;
    end else if (state == P_FETCH) begin
      pat      <= head_rom[4:0];
      elems    <= head_rom[7:5];
      gap_long <= (head_rom[7:5] == 3'd0);
    end else if (state == P_ELEM_GAP && next_state != P_ELEM_GAP) begin
      pat   <= {pat[3:0], 1'b0};
      elems <= elems - 3'd1;
    end
  end

  always_comb begin
    busy      = (state != P_IDLE);
    dit_out   = (state == P_ELEM_ON) && !pat[4];
    dah_out   = (state == P_ELEM_ON) && pat[4];
    morse_out = dit_out | dah_out;
  end

endmodule

// File: tb/tb_ps2_morse_encoder.sv
// Bench for ps2_morse_encoder: drives PS/2 frames, models the typed buffer at the character
// level and checks the played element/gap run lengths against ITU Morse timing.
module tb_ps2_morse_encoder;
  localparam int U = 50;
  localparam int TO = 400;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  logic dit_out, dah_out, morse_out, busy;

  ps2_morse_encoder #(.UNIT_CYCLES(U), .BUF_DEPTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .dit_out(dit_out), .dah_out(dah_out), .morse_out(morse_out), .busy(busy)
  );

  always #10 clk = ~clk;

  int compared = 0, mismatched = 0;
  int hp = 10;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  logic [7:0] m_buf[$];
  logic [7:0] play_text[$];
  logic [7:0] char_codes[$];
  logic m_skip = 1'b0, m_busy = 1'b0, play_start = 1'b0;
  int play_done = 0, act_seen = 0, overlap_err = 0, morse_err = 0, stray = 0;
  int cur_lvl = 0, cur_len = 0, lvl;
  logic [7:0] seq4 [17] = '{8'h1C, 8'h29, 8'h32, 8'h1C, 8'h1C, 8'h29, 8'h32, 8'h1C, 8'h1C,
                            8'h29, 8'h32, 8'h1C, 8'h21, 8'h1C, 8'h29, 8'h32, 8'h1C};

  task automatic chk(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sc2ch(input logic [7:0] b);
    case (b)
      8'h1C: return "A"; 8'h32: return "B"; 8'h21: return "C"; 8'h23: return "D";
      8'h24: return "E"; 8'h2B: return "F"; 8'h34: return "G"; 8'h33: return "H";
      8'h43: return "I"; 8'h3B: return "J"; 8'h42: return "K"; 8'h4B: return "L";
      8'h3A: return "M"; 8'h31: return "N"; 8'h44: return "O"; 8'h4D: return "P";
      8'h15: return "Q"; 8'h2D: return "R"; 8'h1B: return "S"; 8'h2C: return "T";
      8'h3C: return "U"; 8'h2A: return "V"; 8'h1D: return "W"; 8'h22: return "X";
      8'h35: return "Y"; 8'h1A: return "Z"; 8'h45: return "0"; 8'h16: return "1";
      8'h1E: return "2"; 8'h26: return "3"; 8'h25: return "4"; 8'h2E: return "5";
      8'h36: return "6"; 8'h3D: return "7"; 8'h3E: return "8"; 8'h46: return "9";
      8'h29: return " ";
      default: return 8'h00;
    endcase
  endfunction

  function automatic string morse_of(input logic [7:0] c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";  "0": return "-----"; "1": return ".----";
      "2": return "..---"; "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Run-length capture of the outputs while busy; level 0 = silent, 1 = dit, 2 = dah.
  always @(negedge clk) begin
    lvl = dah_out ? 2 : (dit_out ? 1 : 0);
    if (dit_out && dah_out) overlap_err++;
    if (morse_out !== (dit_out | dah_out)) morse_err++;
    if (busy || dit_out || dah_out) act_seen = 1;
    if (busy) begin
      if (cur_len > 0 && lvl == cur_lvl) cur_len++;
      else begin
        if (cur_len > 0) act_q.push_back({2'(cur_lvl), 14'(cur_len)});
        cur_lvl = lvl;
        cur_len = 1;
      end
    end else begin
      if (dit_out || dah_out) stray++;
      if (cur_len > 0) begin
        act_q.push_back({2'(cur_lvl), 14'(cur_len)});
        cur_len = 0;
        play_done++;
      end
    end
  end

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (m_skip) begin m_skip = 1'b0; return; end
    if (b == 8'hF0) begin m_skip = 1'b1; return; end
    if (m_busy) return;
    if (b == 8'h5A) begin
      if (m_buf.size() > 0) begin
        play_text = m_buf;
        m_buf.delete();
        play_start = 1'b1;
      end
    end else if (b == 8'h0C) m_buf.delete();
    else if (sc2ch(b) != 8'h00 && m_buf.size() < 16) m_buf.push_back(sc2ch(b));
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (hp) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (hp) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic key(input logic [7:0] code);
    send_frame(code, 1'b0);
    model_byte(code);
  endtask

  task automatic idle_clocks(input int n);
    ps2_data = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (hp) @(posedge clk); ps2_clk = 1'b0;
      repeat (hp) @(posedge clk); ps2_clk = 1'b1;
    end
  endtask

  task automatic partial_frame(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      repeat (hp) @(posedge clk); ps2_clk = 1'b0;
      repeat (hp) @(posedge clk); ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (TO + 100) @(posedge clk);
  endtask

  task automatic push_seg(input int l, input int len);
    logic [W-1:0] last;
    if (l == 0 && exp_q.size() > 0 && exp_q[exp_q.size()-1][15:14] == 2'd0) begin
      last = exp_q.pop_back();
      exp_q.push_back({2'd0, 14'(int'(last[13:0]) + len)});
    end else exp_q.push_back({2'(l), 14'(len)});
  endtask

  task automatic check_play();
    string m;
    int total, lead;
    logic [W-1:0] a0, e0;
    exp_q.delete();
    foreach (play_text[i]) begin
      if (play_text[i] == " ") push_seg(0, 4 * U);
      else begin
        m = morse_of(play_text[i]);
        for (int j = 0; j < m.len(); j++) begin
          if (m[j] == "-") push_seg(2, 3 * U); else push_seg(1, U);
          push_seg(0, U);
        end
        push_seg(0, 2 * U);
      end
    end
    total = 0;
    foreach (exp_q[i]) total += int'(exp_q[i][13:0]);
    for (int k = 0; k < total + 200 && play_done == 0; k++) @(posedge clk);
    chk("play_done", int'(play_done > 0), 1);
    if (play_done == 0) return;
    chk("seg_present", int'(act_q.size() > 0), 1);
    if (act_q.size() > 0) begin
      a0 = act_q[0];
      e0 = exp_q[0];
      if (e0[15:14] == 2'd0) begin
        lead = int'(a0[13:0]) - int'(e0[13:0]);
        chk("lead_gap", int'(a0[15:14] == 2'd0 && lead >= 0 && lead <= 3), 1);
        void'(exp_q.pop_front());
      end else begin
        chk("lead_idle", int'(a0[15:14] == 2'd0 && a0[13:0] <= 14'd3), 1);
      end
      void'(act_q.pop_front());
    end
    chk("seg_count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("seg%0d_lvl", i), int'(act_q[i][15:14]), int'(exp_q[i][15:14]));
      chk($sformatf("seg%0d_len", i), int'(act_q[i][13:0]), int'(exp_q[i][13:0]));
    end
  endtask

  task automatic start_capture();
    act_q.delete();
    play_done = 0;
    act_seen = 0;
  endtask

  task automatic enter(input int during);
    start_capture();
    key(8'h5A);
    if (play_start) begin
      play_start = 1'b0;
      m_busy = 1'b1;
      if (during >= 0) key(8'(during));
      check_play();
      m_busy = 1'b0;
    end else begin
      repeat (300) @(posedge clk);
      chk("no_play", act_seen, 0);
    end
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    for (int b = 0; b < 256; b++) if (sc2ch(8'(b)) != 8'h00) char_codes.push_back(8'(b));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_dit", dit_out, 0);
    chk("rst_dah", dah_out, 0);
    chk("rst_morse", morse_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    key(8'h1C); enter(-1);
    key(8'h1C); key(8'h29); key(8'h32); enter(-1);
    key(8'hF0); key(8'h21); enter(-1);
    key(8'h21); enter(-1);
    foreach (seq4[i]) key(seq4[i]);
    enter(-1);
    key(8'h1C); key(8'h32); key(8'h21); key(8'h0C); key(8'h29);
    repeat (1000) @(posedge clk);
    enter(-1);
    send_frame(8'h1C, 1'b1); enter(-1);

    idle_clocks(6);
    partial_frame(4);
    key(8'hE0); key(8'h1C); key(8'h32); enter(8'h1C);
    enter(-1);
    key(8'h1C); enter(8'hF0);
    key(8'h32); enter(-1);

    for (int r = 0; r < 4; r++) begin
      hp = $urandom_range(6, 14);
      for (int n = $urandom_range(1, 6); n > 0; n--) begin
        if ($urandom_range(0, 4) == 0) begin
          key(8'hF0);
          key(char_codes[$urandom_range(0, char_codes.size() - 1)]);
        end
        if ($urandom_range(0, 5) == 0) key(8'hE0);
        key(char_codes[$urandom_range(0, char_codes.size() - 1)]);
      end
      enter(-1);
    end

    hp = 10;
    key(8'h1C); key(8'h32); key(8'h21);
    start_capture();
    key(8'h5A);
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_dit", dit_out, 0);
    chk("midrst_dah", dah_out, 0);
    chk("midrst_morse", morse_out, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    m_buf.delete(); m_skip = 1'b0; m_busy = 1'b0; play_start = 1'b0;
    repeat (3) @(posedge clk);
    enter(-1);

    chk("dit_dah_overlap", overlap_err, 0);
    chk("morse_is_or", morse_err, 0);
    chk("stray_idle_output", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
